// File: rtl/serial_pkg.sv
// Shared types for the serial datapath: transfer state and effective-length helper.
package serial_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } serial_state_t;

    // A requested length of 0, or one beyond the operand width, means "full width".
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
        return (len == 0 || len > width) ? width : len;
    endfunction

endpackage

// File: rtl/serial_operand_serializer.sv
// Converts parallel operand pairs into an LSB-first bit-serial vld/a/b/last stream
// for the serial adder; upstream valid/ready, downstream pause-only flow control.
module serial_operand_serializer
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [LEN_W-1:0] in_len,
    input  logic             pause,
    output logic             vld,
    output logic             a,
    output logic             b,
    output logic             last
);

    serial_state_t    state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [LEN_W-1:0] rem;
    logic [LEN_W-1:0] len_eff;
    logic             hs;

    assign len_eff = LEN_W'(eff_len(32'(in_len), WIDTH));

    // Ready also on the cycle the final bit is presented, giving gapless back-to-back transfers.
    assign in_rdy = rst && !pause && (state == IDLE || rem == '0);
    assign hs     = in_vld && in_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            rem   <= '0;
            vld   <= 1'b0;
            a     <= 1'b0;
            b     <= 1'b0;
            last  <= 1'b0;
        end else if (hs) begin
            state <= SEND;
            a     <= in_a[0];
            b     <= in_b[0];
            vld   <= 1'b1;
            last  <= (len_eff == LEN_W'(1));
            sh_a  <= in_a >> 1;
            sh_b  <= in_b >> 1;
            rem   <= len_eff - LEN_W'(1);
        end else if (state == SEND && rem != '0 && !pause) begin
            a     <= sh_a[0];
            b     <= sh_b[0];
            vld   <= 1'b1;
            last  <= (rem == LEN_W'(1));
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            rem   <= rem - LEN_W'(1);
        end else if (state == SEND && rem == '0) begin
            state <= IDLE;
            vld   <= 1'b0;
            a     <= 1'b0;
            b     <= 1'b0;
            last  <= 1'b0;
        end else begin
            // Idle or paused: hold shift state, present a bubble.
            vld   <= 1'b0;
            a     <= 1'b0;
            b     <= 1'b0;
            last  <= 1'b0;
        end
    end

    a_quiet_when_invalid : assert property (@(posedge clk) disable iff (!rst)
        !vld |-> (!a && !b && !last));

    a_last_implies_vld : assert property (@(posedge clk) disable iff (!rst)
        last |-> vld);

    a_rem_in_range : assert property (@(posedge clk) disable iff (!rst)
        32'(rem) < WIDTH);

endmodule
